// File: rtl/sb_txn_capture.sv
// -----------------------------------------------------------------------------
// sb_txn_capture
//
// Passive capture stage that feeds the scoreboard subscribers. It watches one
// valid/ready port of the DUT. Each transfer is stamped with the cycle
// timestamp and a sequence number, then stored in a show-ahead FIFO that the
// monitor drains at its own pace. An overflow is always recorded: drop_cnt
// counts the dropped transfers, and the next stored entry carries out_gap=1.
//
// Handshake semantics (snooped and output side alike): a beat moves in a cycle
// where valid and ready are both 1 at the rising edge. valid may be asserted
// without waiting for ready. On the output side, out_* stay stable while
// out_valid=1 and out_ready=0. out_ready while empty is ignored.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   enable     : 1 = capture transfers, 0 = ignore the snooped port
//   flush      : pulse, discard all FIFO contents (wins over push/pop)
//   mon_valid  : snooped DUT valid
//   mon_ready  : snooped DUT ready
//   mon_data   : snooped DUT payload
//   out_valid  : FIFO head entry present
//   out_ready  : monitor accepts the head entry
//   out_data   : head payload            (0 while empty)
//   out_ts     : head timestamp          (0 while empty)
//   out_seq    : head sequence number    (0 while empty)
//   out_gap    : transfers were dropped just before this entry (0 while empty)
//   level      : FIFO occupancy
//   drop_cnt   : dropped transfers, saturating
//   dbg_state  : control FSM state (0 IDLE, 1 RUN, 2 FLUSH)
// -----------------------------------------------------------------------------
module sb_txn_capture #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 32,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic              mon_valid,
  input  logic              mon_ready,
  input  logic [DATA_W-1:0] mon_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TS_W-1:0]   out_ts,
  output logic [SEQ_W-1:0]  out_seq,
  output logic              out_gap,
  output logic [LVL_W-1:0]  level,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t r_state;

  logic [TS_W-1:0]   r_ts;
  logic [SEQ_W-1:0]  r_seq;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              r_gap_pend;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [TS_W-1:0]   r_mem_ts   [DEPTH];
  logic [SEQ_W-1:0]  r_mem_seq  [DEPTH];
  logic              r_mem_gap  [DEPTH];

  logic w_xfer;
  logic w_not_empty;
  logic w_full;
  logic w_pop_req;
  logic w_free;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_xfer      = enable & mon_valid & mon_ready;
  assign w_not_empty = (r_level != '0);
  assign w_full      = (r_level == LVL_W'(DEPTH));
  assign w_pop_req   = w_not_empty & out_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_free      = ~w_full | w_pop_req;
  // Flush overrides both directions; an xfer during flush is counted as lost.
  assign w_push      = w_xfer & w_free & ~flush;
  assign w_pop       = w_pop_req & ~flush;
  assign w_drop      = w_xfer & (~w_free | flush);

  // Payload storage carries no reset; the outputs are gated while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= mon_data;
      r_mem_ts[r_wr_ptr]   <= r_ts;
      r_mem_seq[r_wr_ptr]  <= r_seq;
      r_mem_gap[r_wr_ptr]  <= r_gap_pend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts       <= '0;
      r_seq      <= '0;
      r_drop_cnt <= '0;
      r_gap_pend <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);

      if (w_xfer) begin
        r_seq <= r_seq + SEQ_W'(1);
      end

      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end

      if (flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_level    <= '0;
        // Discarded entries or a lost xfer both leave a hole in the stream.
        r_gap_pend <= r_gap_pend | w_not_empty | w_xfer;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LVL_W'(1);
          2'b01:   r_level <= r_level - LVL_W'(1);
          default: r_level <= r_level;
        endcase
        if (w_push) begin
          r_gap_pend <= 1'b0;
        end else if (w_drop) begin
          r_gap_pend <= 1'b1;
        end
      end
    end
  end

  // Control FSM: tracks the operating mode; FLUSH lasts exactly one cycle
  // unless flush is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN, ST_FLUSH: begin
          if (flush) begin
            r_state <= ST_FLUSH;
          end else if (enable) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = r_state;
  assign out_valid = w_not_empty;
  assign out_data  = w_not_empty ? r_mem_data[r_rd_ptr] : '0;
  assign out_ts    = w_not_empty ? r_mem_ts[r_rd_ptr]   : '0;
  assign out_seq   = w_not_empty ? r_mem_seq[r_rd_ptr]  : '0;
  assign out_gap   = w_not_empty ? r_mem_gap[r_rd_ptr]  : 1'b0;
  assign level     = r_level;
  assign drop_cnt  = r_drop_cnt;

endmodule
